// File: rtl/serial_parity_checker.sv
// rtl/serial_parity_checker.sv - deserializes LSB-first parity frames and flags parity errors
module serial_parity_checker #(
    parameter int DATA_BITS  = 8,
    parameter int ODD_PARITY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 in_bit,
    input  logic                 in_abort,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_par_err,
    output logic                 overflow,
    output logic                 busy
);

    localparam int CW = $clog2(DATA_BITS + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   acc_q, acc_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   out_valid_q, out_valid_d;
    logic [DATA_BITS-1:0]   out_data_q, out_data_d;
    logic                   out_par_err_q, out_par_err_d;
    logic                   overflow_q, overflow_d;

    logic                   exp_par;
    logic                   out_free;

    // Expected parity from the running XOR; odd parity inverts it.
    always_comb begin
        exp_par  = (ODD_PARITY != 0) ? ~acc_q : acc_q;
        out_free = ~out_valid_q | out_ready;
    end

    // Next-state, datapath and output-register updates.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        acc_d         = acc_q;
        shift_d       = shift_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_par_err_d = out_par_err_q;
        overflow_d    = overflow_q;

        // A handshake frees the output register unless a frame reloads it below.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (in_abort) begin
            // Discard the frame in flight; the output side is left alone.
            state_d = S_IDLE;
            count_d = '0;
            acc_d   = 1'b0;
        end else if (in_valid) begin
            unique case (state_q)
                S_IDLE: begin
                    shift_d[0] = in_bit;
                    acc_d      = in_bit;
                    count_d    = CW'(1);
                    state_d    = (DATA_BITS == 1) ? S_PARITY : S_DATA;
                end
                S_DATA: begin
                    for (int i = 0; i < DATA_BITS; i++) begin
                        if (count_q == CW'(i)) begin
                            shift_d[i] = in_bit;
                        end
                    end
                    acc_d   = acc_q ^ in_bit;
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(DATA_BITS - 1)) begin
                        state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    if (out_free) begin
                        out_valid_d   = 1'b1;
                        out_data_d    = shift_q;
                        out_par_err_d = (in_bit != exp_par);
                    end else begin
                        overflow_d = 1'b1;
                    end
                    state_d = S_IDLE;
                    count_d = '0;
                    acc_d   = 1'b0;
                end
                default: begin
                    state_d = S_IDLE;
                    count_d = '0;
                    acc_d   = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            count_q       <= '0;
            acc_q         <= 1'b0;
            shift_q       <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_par_err_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            acc_q         <= acc_d;
            shift_q       <= shift_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_par_err_q <= out_par_err_d;
            overflow_q    <= overflow_d;
        end
    end

    // Port mapping; busy follows the registered state so it rises one edge after the first bit.
    always_comb begin
        out_valid   = out_valid_q;
        out_data    = out_data_q;
        out_par_err = out_par_err_q;
        overflow    = overflow_q;
        busy        = (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_serial_parity_checker.sv
// tb/tb_serial_parity_checker.sv - directed self-checking bench for serial_parity_checker
module tb_serial_parity_checker;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_bit;
    logic       in_abort;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_par_err;
    logic       overflow;
    logic       busy;

    int n_checks;
    int n_fail;

    serial_parity_checker #(.DATA_BITS(8), .ODD_PARITY(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .in_abort    (in_abort),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_par_err (out_par_err),
        .overflow    (overflow),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        in_valid = 1'b1;
        in_bit   = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_bit   = 1'b0;
    endtask

    task automatic send_data(input logic [7:0] d);
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i]);
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        idle_cycles(1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++;
        if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
        n_checks++;
        if (out_par_err !== 1'b0) begin n_fail++; $display("FAIL reset_par_err: got %b expected 0", out_par_err); end
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_cycles(1);
    endtask

    task automatic test_good_frame();
        out_ready = 1'b1;
        send_data(8'hA5);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL good_early_valid: got %b expected 0", out_valid); end
        send_bit(1'b1);
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL good_valid: got %b expected 1", out_valid); end
        n_checks++;
        if (out_data !== 8'hA5) begin n_fail++; $display("FAIL good_data: got %h expected a5", out_data); end
        n_checks++;
        if (out_par_err !== 1'b0) begin n_fail++; $display("FAIL good_par_err: got %b expected 0", out_par_err); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL good_busy_after: got %b expected 0", busy); end
        idle_cycles(1);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL good_valid_one_cycle: got %b expected 0", out_valid); end
    endtask

    task automatic test_bad_parity();
        out_ready = 1'b1;
        send_data(8'hA5);
        send_bit(1'b0);
        n_checks++;
        if (out_data !== 8'hA5) begin n_fail++; $display("FAIL bad_data: got %h expected a5", out_data); end
        n_checks++;
        if (out_par_err !== 1'b1) begin n_fail++; $display("FAIL bad_par_err: got %b expected 1", out_par_err); end
        send_data(8'h01);
        send_bit(1'b0);
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL x01_valid: got %b expected 1", out_valid); end
        n_checks++;
        if (out_data !== 8'h01) begin n_fail++; $display("FAIL x01_data: got %h expected 01", out_data); end
        n_checks++;
        if (out_par_err !== 1'b0) begin n_fail++; $display("FAIL x01_par_err: got %b expected 0", out_par_err); end
        drain();
    endtask

    task automatic test_simultaneous();
        out_ready = 1'b0;
        send_data(8'h81);
        send_bit(1'b1);
        send_data(8'h7E);
        n_checks++;
        if (out_data !== 8'h81 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL sim_hold: got data %h valid %b expected 81 1", out_data, out_valid);
        end
        out_ready = 1'b1;
        send_bit(1'b0);
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sim_valid: got %b expected 1", out_valid); end
        n_checks++;
        if (out_data !== 8'h7E) begin n_fail++; $display("FAIL sim_data: got %h expected 7e", out_data); end
        n_checks++;
        if (out_par_err !== 1'b1) begin n_fail++; $display("FAIL sim_par_err: got %b expected 1", out_par_err); end
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL sim_overflow: got %b expected 0", overflow); end
        drain();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        send_data(8'h3C);
        send_bit(1'b1);
        n_checks++;
        if (out_data !== 8'h3C || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL b2b_first: got data %h valid %b expected 3c 1", out_data, out_valid);
        end
        send_data(8'hFF);
        send_bit(1'b1);
        n_checks++;
        if (out_data !== 8'h3C) begin n_fail++; $display("FAIL b2b_held_data: got %h expected 3c", out_data); end
        n_checks++;
        if (out_par_err !== 1'b0) begin n_fail++; $display("FAIL b2b_par_err: got %b expected 0", out_par_err); end
        n_checks++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL b2b_overflow: got %b expected 1", overflow); end
        out_ready = 1'b1;
        idle_cycles(1);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_consumed: got %b expected 0", out_valid); end
        n_checks++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL b2b_overflow_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_gaps();
        logic [7:0] d;
        d = 8'h5A;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i]);
            idle_cycles((i % 2 == 0) ? 1 : 3);
            n_checks++;
            if (busy !== 1'b1 || out_valid !== 1'b0) begin
                n_fail++; $display("FAIL gap_busy_bit%0d: got busy %b valid %b expected 1 0", i, busy, out_valid);
            end
        end
        send_bit(1'b1);
        n_checks++;
        if (out_data !== 8'h5A || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL gap_data: got data %h valid %b expected 5a 1", out_data, out_valid);
        end
        n_checks++;
        if (out_par_err !== 1'b0) begin n_fail++; $display("FAIL gap_par_err: got %b expected 0", out_par_err); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL gap_busy_end: got %b expected 0", busy); end
        drain();
    endtask

    task automatic test_abort();
        out_ready = 1'b1;
        send_data(8'hC3);
        in_abort = 1'b1;
        send_bit(1'b1);
        in_abort = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_parity: got valid %b busy %b expected 0 0", out_valid, busy);
        end
        for (int i = 0; i < 4; i++) begin
            send_bit(1'b1);
        end
        in_abort = 1'b1;
        idle_cycles(1);
        in_abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL abort_mid: got busy %b valid %b expected 0 0", busy, out_valid);
        end
        send_data(8'h0F);
        send_bit(1'b1);
        n_checks++;
        if (out_data !== 8'h0F || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL abort_next_data: got data %h valid %b expected 0f 1", out_data, out_valid);
        end
        n_checks++;
        if (out_par_err !== 1'b0) begin n_fail++; $display("FAIL abort_next_par_err: got %b expected 0", out_par_err); end
        idle_cycles(3);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_extra_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_pre_busy: got %b expected 1", busy); end
        rst_n = 1'b0;
        #2;
        n_checks++;
        if (busy !== 1'b0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid: got busy %b overflow %b expected 0 0", busy, overflow);
        end
        rst_n = 1'b1;
        idle_cycles(1);
        out_ready = 1'b0;
        send_data(8'hE7);
        send_bit(1'b0);
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid: got %b expected 1", out_valid); end
        rst_n = 1'b0;
        #2;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_par_err !== 1'b0) begin
            n_fail++; $display("FAIL rst_out: got valid %b data %h err %b expected 0 00 0", out_valid, out_data, out_par_err);
        end
        rst_n = 1'b1;
        idle_cycles(1);
        out_ready = 1'b1;
        send_data(8'h00);
        send_bit(1'b1);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h00) begin
            n_fail++; $display("FAIL rst_x00: got valid %b data %h expected 1 00", out_valid, out_data);
        end
        n_checks++;
        if (out_par_err !== 1'b0) begin n_fail++; $display("FAIL rst_x00_par_err: got %b expected 0", out_par_err); end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        in_abort  = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_good_frame();
        test_bad_parity();
        test_simultaneous();
        test_back_to_back();
        test_gaps();
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
